mem_arbiter: RTL

Byte-serial memory controller that shares the single 8-bit RAM port between instruction fetch (IF) and the load/store stage (MEM). It sits between the fetch unit and the `ex_mem`-fed MEM stage on one side and the external RAM on the other. It serializes 1/2/4-byte accesses into byte cycles and assembles little-endian words. It raises per-stage stall requests for the pipeline `ctrl` while a requester waits.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and byte-wide RAM signals around mem_arbiter.
// The arbiter takes the slave view; the pipeline/RAM side takes the master view.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_cancel;
  logic        if_ack;
  logic [31:0] if_data;

  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  logic        stallreq_if;
  logic        stallreq_mem;

  modport slave (
    input  if_req, if_addr, if_cancel, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    output if_ack, if_data, mem_ack, mem_rdata, ram_a, ram_dout, ram_wr, stallreq_if, stallreq_mem
  );

  modport master (
    output if_req, if_addr, if_cancel, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_ack, if_data, mem_ack, mem_rdata, ram_a, ram_dout, ram_wr, stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial controller sharing one 8-bit RAM port between instruction fetch and
// load/store; serializes 1/2/4-byte accesses and assembles little-endian words.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;

  logic        if_ack;
  logic        mem_ack;
  logic        load_ack;
  logic [2:0]  mem_n;
  logic [1:0]  rd_byte;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;

  assign mem_n   = (bus.mem_size == 2'd0) ? 3'd1 :
                   (bus.mem_size == 2'd1) ? 3'd2 : 3'd4;
  // RAM data lags the address by a cycle, so the byte arriving now belongs to cnt-1.
  assign rd_byte = 2'(cnt_q - 3'd1);

  assign if_ack   = (state_q == S_DONE) && (owner_q == OWN_IF) && !bus.if_cancel;
  assign mem_ack  = (state_q == S_DONE) && (owner_q == OWN_MEM);
  assign load_ack = mem_ack && !we_q;

  always_comb begin
    // NOTE: every variable gets its hold/idle value first so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    ram_a       = '0;
    ram_dout    = '0;
    ram_wr      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.mem_req) begin
          owner_d = OWN_MEM;
          base_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          n_d     = mem_n;
          we_d    = bus.mem_we;
          cnt_d   = '0;
          buf_d   = '0;
          state_d = bus.mem_we ? S_WRITE : S_READ;
        end else if (bus.if_req && !bus.if_cancel) begin
          owner_d = OWN_IF;
          base_d  = bus.if_addr;
          n_d     = 3'd4;
          we_d    = 1'b0;
          cnt_d   = '0;
          buf_d   = '0;
          state_d = S_READ;
        end
      end

      S_READ: begin
        ram_a = base_q + {29'd0, cnt_q};
        if (owner_q == OWN_IF && bus.if_cancel) begin
          state_d = S_IDLE;
        end else begin
          if (cnt_q != 3'd0) buf_d[{rd_byte, 3'b000} +: 8] = bus.ram_din;
          if (cnt_q == n_q) state_d = S_DONE;
          else              cnt_d   = cnt_q + 3'd1;
        end
      end

      S_WRITE: begin
        ram_a    = base_q + {29'd0, cnt_q};
        ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        ram_wr   = 1'b1;
        if (cnt_q == n_q - 3'd1) state_d = S_DONE;
        else                     cnt_d   = cnt_q + 3'd1;
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (if_ack)   if_data_d   = buf_q;
        if (load_ack) mem_rdata_d = buf_q;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
    end
  end

  // Data is presented straight from the assembly buffer during the ack cycle.
  assign bus.if_ack       = if_ack;
  assign bus.if_data      = if_ack ? buf_q : if_data_q;
  assign bus.mem_ack      = mem_ack;
  assign bus.mem_rdata    = load_ack ? buf_q : mem_rdata_q;
  assign bus.ram_a        = ram_a;
  assign bus.ram_dout     = ram_dout;
  assign bus.ram_wr       = ram_wr;
  assign bus.stallreq_if  = bus.if_req & ~if_ack;
  assign bus.stallreq_mem = bus.mem_req & ~mem_ack;

endmodule
